// File: rtl/checkpoint_allocator_pkg.sv
// Shared types for checkpoint_allocator: checkpoint id width helper and the
// per-slot record (busy flag plus snapshot of the resource free mask).
package checkpoint_allocator_pkg;

  // Upper bound on NUM_RESOURCES; a slot snapshot uses the low NUM_RESOURCES bits.
  localparam int MAX_RESOURCES = 128;

  function automatic int chkpt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                     busy;
    logic [MAX_RESOURCES-1:0] snapshot;
  } chkpt_slot_t;

endpackage

// File: rtl/checkpoint_allocator_nth_free_select.sv
// nth_free_select: the k-th active requester (ascending index) is handed the
// k-th lowest set bit of avail; enough flags that every active request fits.
module nth_free_select #(
  parameter int WIDTH   = 8,
  parameter int NUM_SEL = 1
) (
  input  logic [WIDTH-1:0]              avail,
  input  logic [NUM_SEL-1:0]            req,
  output logic [NUM_SEL-1:0][WIDTH-1:0] sel,
  output logic                          enough
);

  int n_req;
  int n_avail;
  int seen;

  always_comb begin
    sel     = '0;
    n_req   = 0;
    n_avail = 0;
    seen    = 0;
    for (int b = 0; b < WIDTH; b++) begin
      if (avail[b]) n_avail++;
    end
    for (int i = 0; i < NUM_SEL; i++) begin
      if (req[i]) begin
        // n_req is this requester's rank among the active ones
        seen = 0;
        for (int b = 0; b < WIDTH; b++) begin
          if (avail[b]) begin
            if (seen == n_req) sel[i][b] = 1'b1;
            seen++;
          end
        end
        n_req++;
      end
    end
    enough = (n_req <= n_avail);
  end

endmodule

// File: rtl/checkpoint_allocator.sv
// Resource allocator with checkpoint/restore of the free mask for mispredict
// recovery. Define ALLOC_CLEAR_BYPASS_EN to make same-cycle clears grantable.
module checkpoint_allocator
  import checkpoint_allocator_pkg::*;
#(
  parameter int                       NUM_RESOURCES   = 64,
  parameter int                       NUM_REQUESTS    = 3,
  parameter int                       NUM_CHECKPOINTS = 4,
  parameter logic [NUM_RESOURCES-1:0] INIT_MASK       = '1,
  localparam int                      CHKPT_W         = chkpt_w(NUM_CHECKPOINTS),
  localparam int                      CNT_W           = $clog2(NUM_RESOURCES + 1)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUM_REQUESTS-1:0]                     req,
  input  logic [NUM_RESOURCES-1:0]                    clear,
  output logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0]  grant,
  output logic                                        alloc_ok,
  output logic [NUM_RESOURCES-1:0]                    resource_status,
  output logic [CNT_W-1:0]                            free_count,
  input  logic                                        save_req,
  output logic                                        save_ack,
  output logic [CHKPT_W-1:0]                          save_id,
  input  logic                                        resolve_valid,
  input  logic [CHKPT_W-1:0]                          resolve_id,
  input  logic                                        restore_valid,
  input  logic [CHKPT_W-1:0]                          restore_id,
  input  logic [NUM_CHECKPOINTS-1:0]                  restore_release,
  output logic                                        chkpt_full
);

  chkpt_slot_t slots_q [NUM_CHECKPOINTS];
  chkpt_slot_t slots_d [NUM_CHECKPOINTS];

  logic [NUM_RESOURCES-1:0]                   candidates;
  logic [NUM_RESOURCES-1:0]                   granted;
  logic [NUM_RESOURCES-1:0]                   restore_snap;
  logic [NUM_RESOURCES-1:0]                   status_d;
  logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0] res_sel;
  logic                                       res_enough;
  logic [NUM_CHECKPOINTS-1:0]                 slot_busy;
  logic [0:0][NUM_CHECKPOINTS-1:0]            slot_sel;
  logic                                       unused_slot_enough;

`ifdef ALLOC_CLEAR_BYPASS_EN
  assign candidates = resource_status | clear;
`else
  assign candidates = resource_status;
`endif

  nth_free_select #(
    .WIDTH   (NUM_RESOURCES),
    .NUM_SEL (NUM_REQUESTS)
  ) u_res_select (
    .avail  (candidates),
    .req    (req),
    .sel    (res_sel),
    .enough (res_enough)
  );

  // All-or-nothing: a short supply or a restore suppresses every grant.
  always_comb begin
    grant    = '0;
    alloc_ok = 1'b0;
    if (reset && !restore_valid && res_enough) begin
      grant    = res_sel;
      alloc_ok = 1'b1;
    end
  end

  always_comb begin
    granted = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) granted = granted | grant[i];
  end

  always_comb begin
    restore_snap = '0;
    for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
      if (restore_id == CHKPT_W'(i)) restore_snap = slots_q[i].snapshot[NUM_RESOURCES-1:0];
    end
  end

  assign status_d = restore_valid ? (restore_snap | clear)
                                  : ((resource_status | clear) & ~granted);

  always_comb begin
    for (int i = 0; i < NUM_CHECKPOINTS; i++) slot_busy[i] = slots_q[i].busy;
  end

  assign chkpt_full = &slot_busy;
  assign save_ack   = reset && save_req && !chkpt_full && !restore_valid;

  // Slot choice looks only at registered busy bits, so a same-cycle resolve
  // never makes its slot available to a save.
  nth_free_select #(
    .WIDTH   (NUM_CHECKPOINTS),
    .NUM_SEL (1)
  ) u_slot_select (
    .avail  (~slot_busy),
    .req    (1'b1),
    .sel    (slot_sel),
    .enough (unused_slot_enough)
  );

  always_comb begin
    save_id = '0;
    for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
      if (slot_sel[0][i]) save_id = CHKPT_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
      slots_d[i] = slots_q[i];
      if (slots_q[i].busy) begin
        slots_d[i].snapshot[NUM_RESOURCES-1:0] = slots_q[i].snapshot[NUM_RESOURCES-1:0] | clear;
      end
      if (resolve_valid && resolve_id == CHKPT_W'(i)) slots_d[i].busy = 1'b0;
      if (restore_valid && (restore_release[i] || restore_id == CHKPT_W'(i))) begin
        slots_d[i].busy = 1'b0;
      end
      if (save_ack && save_id == CHKPT_W'(i)) begin
        slots_d[i].busy                        = 1'b1;
        slots_d[i].snapshot[NUM_RESOURCES-1:0] = status_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resource_status <= INIT_MASK;
      for (int i = 0; i < NUM_CHECKPOINTS; i++) slots_q[i] <= '0;
    end else begin
      resource_status <= status_d;
      for (int i = 0; i < NUM_CHECKPOINTS; i++) slots_q[i] <= slots_d[i];
    end
  end

  always_comb begin
    free_count = '0;
    for (int b = 0; b < NUM_RESOURCES; b++) free_count = free_count + CNT_W'(resource_status[b]);
  end

endmodule

// File: tb/tb_checkpoint_allocator.sv
// Bench for checkpoint_allocator: directed scenarios then randomized traffic,
// each cycle checked against a behavioural model of the allocation rules.
module tb_checkpoint_allocator;

  localparam int         NR   = 8;
  localparam int         NQ   = 3;
  localparam int         NC   = 2;
  localparam logic [7:0] INIT = 8'hF0;

  logic                clock = 1'b0;
  logic                reset;
  logic [NQ-1:0]       req;
  logic [NR-1:0]       clear;
  logic [NQ-1:0][NR-1:0] grant;
  logic                alloc_ok;
  logic [NR-1:0]       resource_status;
  logic [3:0]          free_count;
  logic                save_req;
  logic                save_ack;
  logic [0:0]          save_id;
  logic                resolve_valid;
  logic [0:0]          resolve_id;
  logic                restore_valid;
  logic [0:0]          restore_id;
  logic [NC-1:0]       restore_release;
  logic                chkpt_full;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  logic [7:0] m_status;
  logic       m_busy [NC];
  logic [7:0] m_snap [NC];
  logic [7:0] n_status;
  logic       n_busy [NC];
  logic [7:0] n_snap [NC];

  checkpoint_allocator #(
    .NUM_RESOURCES   (NR),
    .NUM_REQUESTS    (NQ),
    .NUM_CHECKPOINTS (NC),
    .INIT_MASK       (INIT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .clear           (clear),
    .grant           (grant),
    .alloc_ok        (alloc_ok),
    .resource_status (resource_status),
    .free_count      (free_count),
    .save_req        (save_req),
    .save_ack        (save_ack),
    .save_id         (save_id),
    .resolve_valid   (resolve_valid),
    .resolve_id      (resolve_id),
    .restore_valid   (restore_valid),
    .restore_id      (restore_id),
    .restore_release (restore_release),
    .chkpt_full      (chkpt_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset           = 1'b1;
    req             = '0;
    clear           = '0;
    save_req        = 1'b0;
    resolve_valid   = 1'b0;
    resolve_id      = '0;
    restore_valid   = 1'b0;
    restore_id      = '0;
    restore_release = '0;
  endtask

  // Compute expectations from the rules, compare, and form the next state.
  task automatic model_cycle();
    logic [7:0]          cand;
    logic [7:0]          used;
    logic [NQ-1:0][7:0]  e_grant;
    logic                e_ok;
    logic                e_ack;
    logic                e_full;
    int                  e_id;
    int                  free_q[$];
    int                  k;

    cand = m_status;
`ifdef ALLOC_CLEAR_BYPASS_EN
    cand = cand | clear;
`endif
    free_q.delete();
    for (int b = 0; b < NR; b++) if (cand[b]) free_q.push_back(b);
    e_grant = '0;
    e_ok    = 1'b0;
    if (reset && !restore_valid && $countones(req) <= free_q.size()) begin
      e_ok = 1'b1;
      k    = 0;
      for (int i = 0; i < NQ; i++) begin
        if (req[i]) begin
          e_grant[i][free_q[k]] = 1'b1;
          k++;
        end
      end
    end
    used = e_grant[0] | e_grant[1] | e_grant[2];

    e_full = m_busy[0] && m_busy[1];
    e_ack  = reset && save_req && !e_full && !restore_valid;
    e_id   = m_busy[0] ? 1 : 0;

    check("grant", 32'(grant), 32'(e_grant));
    check("alloc_ok", 32'(alloc_ok), 32'(e_ok));
    check("save_ack", 32'(save_ack), 32'(e_ack));
    if (e_ack) check("save_id", 32'(save_id), 32'(e_id));
    check("resource_status", 32'(resource_status), 32'(m_status));
    check("free_count", 32'(free_count), 32'($countones(m_status)));
    check("chkpt_full", 32'(chkpt_full), 32'(e_full));

    if (!reset) begin
      n_status = INIT;
      for (int s = 0; s < NC; s++) begin
        n_busy[s] = 1'b0;
        n_snap[s] = m_snap[s];
      end
    end else begin
      n_status = restore_valid ? (m_snap[restore_id] | clear) : ((m_status | clear) & ~used);
      for (int s = 0; s < NC; s++) begin
        n_snap[s] = m_busy[s] ? (m_snap[s] | clear) : m_snap[s];
        n_busy[s] = m_busy[s];
        if (resolve_valid && int'(resolve_id) == s) n_busy[s] = 1'b0;
        if (restore_valid && (restore_release[s] || int'(restore_id) == s)) n_busy[s] = 1'b0;
      end
      if (e_ack) begin
        n_busy[e_id] = 1'b1;
        n_snap[e_id] = n_status;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
    m_status = n_status;
    for (int s = 0; s < NC; s++) begin
      m_busy[s] = n_busy[s];
      m_snap[s] = n_snap[s];
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(posedge clock);
    #1;
    m_status = INIT;
    for (int s = 0; s < NC; s++) begin
      m_busy[s] = 1'b0;
      m_snap[s] = '0;
    end

    // Held in reset with requests pending: nothing may be granted or saved.
    req      = 3'b111;
    save_req = 1'b1;
    run_cycle();
    check("reset_free_count", 32'(free_count), 32'd4);

    // Two requesters share the two lowest free resources.
    idle_inputs();
    req = 3'b101;
    #1;
    check("r036_grant", 32'(grant), 32'h200010);
    check("r036_ok", 32'(alloc_ok), 32'd1);
    run_cycle();
    check("r036_status", 32'(resource_status), 32'hC0);
    check("r036_count", 32'(free_count), 32'd2);

    // Three requests against two free resources: all-or-nothing.
    req = 3'b111;
    #1;
    check("r037_grant", 32'(grant), 32'h0);
    check("r037_ok", 32'(alloc_ok), 32'd0);
    run_cycle();
    check("r037_status", 32'(resource_status), 32'hC0);
`ifdef ALLOC_CLEAR_BYPASS_EN
    clear = 8'h01;
    #1;
    check("r037_bypass_grant", 32'(grant), 32'h804001);
    run_cycle();
`endif

    // Save, clear into snapshot, allocate, then restore.
    idle_inputs();
    reset = 1'b0;
    run_cycle();
    idle_inputs();
    save_req = 1'b1;
    req      = 3'b001;
    #1;
    check("r038_ack", 32'(save_ack), 32'd1);
    check("r038_id", 32'(save_id), 32'd0);
    run_cycle();
    check("r038_status", 32'(resource_status), 32'hE0);
    idle_inputs();
    clear = 8'h02;
    run_cycle();
    idle_inputs();
    req = 3'b011;
    run_cycle();
    idle_inputs();
    restore_valid = 1'b1;
    restore_id    = 1'b0;
    run_cycle();
    check("r038_restore", 32'(resource_status), 32'hE2);

    // Fill both slots, then a resolve frees one only for the following cycle.
    idle_inputs();
    save_req = 1'b1;
    run_cycle();
    run_cycle();
    #1;
    check("r039_full", 32'(chkpt_full), 32'd1);
    check("r039_noack", 32'(save_ack), 32'd0);
    resolve_valid = 1'b1;
    resolve_id    = 1'b1;
    run_cycle();
    idle_inputs();
    save_req = 1'b1;
    #1;
    check("r039_ack", 32'(save_ack), 32'd1);
    check("r039_id", 32'(save_id), 32'd1);
    run_cycle();

    // Restore releasing both slots while a request is pending.
    idle_inputs();
    restore_valid   = 1'b1;
    restore_id      = 1'b0;
    restore_release = 2'b11;
    req             = 3'b001;
    #1;
    check("r040_grant", 32'(grant), 32'h0);
    check("r040_ok", 32'(alloc_ok), 32'd0);
    run_cycle();
    check("r040_full", 32'(chkpt_full), 32'd0);

    // Reset arriving while a save is acknowledged discards it.
    idle_inputs();
    req = 3'b001;
    run_cycle();
    idle_inputs();
    req      = 3'b011;
    save_req = 1'b1;
    reset    = 1'b0;
    run_cycle();
    check("r041_status", 32'(resource_status), 32'hF0);
    check("r041_full", 32'(chkpt_full), 32'd0);
    idle_inputs();
    save_req = 1'b1;
    #1;
    check("r041_id", 32'(save_id), 32'd0);
    run_cycle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      reset         = ($urandom_range(0, 49) != 0);
      req           = 3'($urandom_range(0, 7));
      clear         = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      save_req      = ($urandom_range(0, 2) == 0);
      resolve_valid = ($urandom_range(0, 3) == 0);
      resolve_id    = 1'($urandom_range(0, 1));
      if ((m_busy[0] || m_busy[1]) && $urandom_range(0, 7) == 0) begin
        restore_valid   = 1'b1;
        restore_id      = m_busy[0] ? 1'b0 : 1'b1;
        if (m_busy[0] && m_busy[1]) restore_id = 1'($urandom_range(0, 1));
        restore_release = 2'($urandom_range(0, 3));
      end
      run_cycle();
    end

    idle_inputs();
    run_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
